hazard_stall_unit: RTL and testbench
====================================

# hazard_stall_unit

Stall/flush controller paired with the pipeline's forwarding unit. Forwarding selects where an operand comes from once its producer is in flight. This block sits at the decode stage and covers the cases forwarding cannot: load-use, values written by IN, and multi-cycle memory access. It holds decode, inserts bubbles into D2E, flushes F2D on taken branches, and freezes the whole pipeline while memory is busy.

## Interface
- NUM_REGS, 8, architectural registers; register addresses are log2(NUM_REGS) = 3 bits
- MEM_LAT, 1, extra freeze cycles per memory access; 0 = single-cycle memory, never freezes

- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- src1AfterF2D, src2AfterF2D  in  3  decode-stage source addresses
- src1UsedF2D, src2UsedF2D  in  1  source actually read by decode instruction
- destAddrAfterF2D  in  3  decode-stage destination
- RWAfterF2D, MTRAfterF2D, isINAfterF2D  in  1  decode instruction writes reg / is load / is IN
- isBranchAfterF2D  in  1  decode instruction is a register-indirect branch (reads src1)
- takenBranch  in  1  branch resolved taken this cycle
- memAccessAfterE2M  in  1  load or store entering MEM
- RWAfterM2W, isINAfterM2W  in  1  writeback valid / writeback is IN result
- MEM_WB_RD  in  3  writeback destination
- stallF2D  out  1  hold PC and F2D
- bubbleD2E  out  1  load NOP into D2E
- flushF2D  out  1  clear F2D
- freezeAll  out  1  hold every pipeline register
- stallCycles  out  16  stall-cycle counter; present only with HAZARD_PERF_CNT_EN

## Operation
- State: FSM {RUN, FREEZE}; down-counter frz; loadInEX bit plus loadDestEX[2:0]; inCnt[r], 2-bit per register.
- Reset: FSM=RUN, frz=0, loadInEX=0, inCnt all 0. All outputs 0. stallCycles=0.
- freezeAll = (state==FREEZE). RUN→FREEZE when memAccessAfterE2M is high in RUN and MEM_LAT>0; frz loads MEM_LAT-1. In FREEZE, frz decrements; at frz==0 go to RUN. memAccessAfterE2M is ignored in FREEZE.
- Load-use: hazLD = loadInEX and some used source (src1 if src1UsedF2D or isBranchAfterF2D; src2 if src2UsedF2D) equals loadDestEX.
- IN hazard: hazIN = some used source r has inCnt[r]!=0. Forwarding is disabled for IN results, so the consumer waits until writeback. The register file writes before it is read, so decode may issue in the writeback cycle if the count reaches 0 that edge. Combinationally, the same-cycle decrement is counted as 0.
- stall = hazLD or hazIN.
- Output priority, all combinational:
  - freezeAll: stallF2D, bubbleD2E and flushF2D = 0.
  - else takenBranch: flushF2D=1, stallF2D=0, bubbleD2E=stall.
  - else stallF2D=bubbleD2E=stall.
- Issue = not freezeAll and not stall. On issue with RWAfterF2D:
  - loadInEX <= MTRAfterF2D and loadDestEX <= destAddrAfterF2D.
  - if isINAfterF2D: inCnt[dest]++, saturating at 3.
  - Otherwise, when not frozen, loadInEX <= 0.
- Writeback, when not frozen: RWAfterM2W and isINAfterM2W decrements inCnt[MEM_WB_RD], floored at 0. An increment and a decrement of the same register in one cycle leave the count unchanged.
- An instruction flushed from F2D never issued, so the scoreboard needs no correction.

## Timing
- Hazard outputs are combinational, with no latency from inputs to outputs. State updates take effect next edge.
- Load-use inserts exactly 1 bubble.
- An IN consumer waits until the producer's writeback cycle: 2 bubbles if it is adjacent to its producer.
- A memory access freezes for MEM_LAT cycles starting the cycle after memAccessAfterE2M.
- rst mid-FREEZE or mid-stall returns to RUN with a cleared scoreboard at the next edge.

## Configuration
- HAZARD_PERF_CNT_EN defined: stallCycles counts cycles with stallF2D or freezeAll high. It saturates at 16'hFFFF and is cleared by rst.
- Undefined: the port and counter are absent; no other behaviour changes.

## Test plan
- Load-use: load to R3, then ADD reading R3 → one cycle stallF2D=bubbleD2E=1, then issue. Forwarded value is taken from memDataAfterM2W.
- Independent after load: load R3, then ADD reading R4 → no stall.
- IN chain: IN R2, then ADD reading R2 → 2 stall cycles. Issues in the cycle RWAfterM2W=1, MEM_WB_RD=2, isINAfterM2W=1. inCnt[2] returns to 0.
- Freeze with MEM_LAT=2: memAccessAfterE2M pulse → freezeAll high exactly 2 cycles. A concurrent load-use stall remains pending after the freeze, then takes 1 bubble.
- Taken branch during load-use stall → flushF2D=1, bubbleD2E=1, stallF2D=0 in the same cycle.
- With HAZARD_PERF_CNT_EN: 3 stall cycles plus 2 freeze cycles → stallCycles=5. rst mid-freeze → freezeAll=0 and stallCycles=0 next cycle.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Decode-stage stall/flush/freeze control for load-use, IN results and slow memory.
// Define HAZARD_PERF_CNT_EN to add the stallCycles performance counter port.
module hazard_stall_unit #(
  parameter int NUM_REGS = 8,
  parameter int MEM_LAT  = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] src1AfterF2D,
  input  logic [AW-1:0] src2AfterF2D,
  input  logic          src1UsedF2D,
  input  logic          src2UsedF2D,
  input  logic [AW-1:0] destAddrAfterF2D,
  input  logic          RWAfterF2D,
  input  logic          MTRAfterF2D,
  input  logic          isINAfterF2D,
  input  logic          isBranchAfterF2D,
  input  logic          takenBranch,
  input  logic          memAccessAfterE2M,
  input  logic          RWAfterM2W,
  input  logic          isINAfterM2W,
  input  logic [AW-1:0] MEM_WB_RD,
  output logic          stallF2D,
  output logic          bubbleD2E,
  output logic          flushF2D,
`ifdef HAZARD_PERF_CNT_EN
  output logic          freezeAll,
  output logic [15:0]   stallCycles
`else
  output logic          freezeAll
`endif
);

  localparam int FW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [FW-1:0] FRZ_INIT =
    FW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  typedef enum logic {RUN, FREEZE} state_e;

  state_e        state_q, state_d;
  logic [FW-1:0] frz_q, frz_d;
  logic          load_in_ex_q, load_in_ex_d;
  logic [AW-1:0] load_dest_ex_q, load_dest_ex_d;
  logic [1:0]    in_cnt_q [NUM_REGS];
  logic [1:0]    in_cnt_d [NUM_REGS];

  logic          use1, use2;
  logic          frozen, wb_dec;
  logic [1:0]    cnt1, cnt2;
  logic          haz_ld, haz_in, stall, issue;

  assign frozen = (state_q == FREEZE);
  assign use1   = src1UsedF2D | isBranchAfterF2D;
  assign use2   = src2UsedF2D;
  assign wb_dec = RWAfterM2W & isINAfterM2W & ~frozen;

  // A writeback this edge frees its register for a same-cycle read.
  always_comb begin
    cnt1 = in_cnt_q[src1AfterF2D];
    cnt2 = in_cnt_q[src2AfterF2D];
    if (wb_dec && MEM_WB_RD == src1AfterF2D && cnt1 != 2'd0)
      cnt1 = cnt1 - 2'd1;
    if (wb_dec && MEM_WB_RD == src2AfterF2D && cnt2 != 2'd0)
      cnt2 = cnt2 - 2'd1;
  end

  assign haz_ld = load_in_ex_q &
    ((use1 && src1AfterF2D == load_dest_ex_q) ||
     (use2 && src2AfterF2D == load_dest_ex_q));
  assign haz_in = (use1 && cnt1 != 2'd0) ||
                  (use2 && cnt2 != 2'd0);
  assign stall  = haz_ld | haz_in;
  assign issue  = ~frozen & ~stall;

  always_comb begin
    freezeAll = frozen;
    stallF2D  = 1'b0;
    bubbleD2E = 1'b0;
    flushF2D  = 1'b0;
    if (frozen) begin
      stallF2D = 1'b0;
    end else if (takenBranch) begin
      flushF2D  = 1'b1;
      bubbleD2E = stall;
    end else begin
      stallF2D  = stall;
      bubbleD2E = stall;
    end
  end

  always_comb begin
    state_d = state_q;
    frz_d   = frz_q;
    unique case (state_q)
      RUN: begin
        if (memAccessAfterE2M && MEM_LAT > 0) begin
          state_d = FREEZE;
          frz_d   = FRZ_INIT;
        end
      end
      FREEZE: begin
        if (frz_q == '0) state_d = RUN;
        else frz_d = frz_q - FW'(1);
      end
    endcase
  end

  // Simultaneous inc and dec of one register cancel out.
  always_comb begin
    load_in_ex_d   = load_in_ex_q;
    load_dest_ex_d = load_dest_ex_q;
    in_cnt_d       = in_cnt_q;
    if (issue && RWAfterF2D) begin
      load_in_ex_d   = MTRAfterF2D;
      load_dest_ex_d = destAddrAfterF2D;
    end else if (!frozen) begin
      load_in_ex_d = 1'b0;
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      if (issue && RWAfterF2D && isINAfterF2D &&
          destAddrAfterF2D == AW'(r) &&
          !(wb_dec && MEM_WB_RD == AW'(r))) begin
        if (in_cnt_q[r] != 2'd3)
          in_cnt_d[r] = in_cnt_q[r] + 2'd1;
      end else if (wb_dec && MEM_WB_RD == AW'(r) &&
                   !(issue && RWAfterF2D && isINAfterF2D &&
                     destAddrAfterF2D == AW'(r))) begin
        if (in_cnt_q[r] != 2'd0)
          in_cnt_d[r] = in_cnt_q[r] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      frz_q          <= '0;
      load_in_ex_q   <= 1'b0;
      load_dest_ex_q <= '0;
      for (int r = 0; r < NUM_REGS; r++)
        in_cnt_q[r] <= 2'd0;
    end else begin
      state_q        <= state_d;
      frz_q          <= frz_d;
      load_in_ex_q   <= load_in_ex_d;
      load_dest_ex_q <= load_dest_ex_d;
      in_cnt_q       <= in_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if ((stallF2D || freezeAll) && stall_cycles_q != 16'hFFFF)
      stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cycles_q <= 16'd0;
    else     stall_cycles_q <= stall_cycles_d;
  end

  assign stallCycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit (MEM_LAT=2).
// Perf counter checks are active when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] src1AfterF2D, src2AfterF2D;
  logic       src1UsedF2D, src2UsedF2D;
  logic [2:0] destAddrAfterF2D;
  logic       RWAfterF2D, MTRAfterF2D, isINAfterF2D;
  logic       isBranchAfterF2D, takenBranch;
  logic       memAccessAfterE2M;
  logic       RWAfterM2W, isINAfterM2W;
  logic [2:0] MEM_WB_RD;
  logic       stallF2D, bubbleD2E, flushF2D, freezeAll;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stallCycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.NUM_REGS(8), .MEM_LAT(2)) dut (
    .clk(clk),
    .rst(rst),
    .src1AfterF2D(src1AfterF2D),
    .src2AfterF2D(src2AfterF2D),
    .src1UsedF2D(src1UsedF2D),
    .src2UsedF2D(src2UsedF2D),
    .destAddrAfterF2D(destAddrAfterF2D),
    .RWAfterF2D(RWAfterF2D),
    .MTRAfterF2D(MTRAfterF2D),
    .isINAfterF2D(isINAfterF2D),
    .isBranchAfterF2D(isBranchAfterF2D),
    .takenBranch(takenBranch),
    .memAccessAfterE2M(memAccessAfterE2M),
    .RWAfterM2W(RWAfterM2W),
    .isINAfterM2W(isINAfterM2W),
    .MEM_WB_RD(MEM_WB_RD),
    .stallF2D(stallF2D),
    .bubbleD2E(bubbleD2E),
    .flushF2D(flushF2D),
    .freezeAll(freezeAll)
`ifdef HAZARD_PERF_CNT_EN
    , .stallCycles(stallCycles)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expo(input string tag, input logic st, input logic bu,
                      input logic fl, input logic fr);
    chk({tag, ".stall"}, {15'd0, stallF2D}, {15'd0, st});
    chk({tag, ".bubble"}, {15'd0, bubbleD2E}, {15'd0, bu});
    chk({tag, ".flush"}, {15'd0, flushF2D}, {15'd0, fl});
    chk({tag, ".freeze"}, {15'd0, freezeAll}, {15'd0, fr});
  endtask

  task automatic perf(input string tag, input logic [15:0] exp);
`ifdef HAZARD_PERF_CNT_EN
    chk({tag, ".cycles"}, stallCycles, exp);
`else
    if (exp == 16'hFFFF) $display("note %s", tag);
`endif
  endtask

  task automatic idle();
    src1AfterF2D = 3'd0; src2AfterF2D = 3'd0;
    src1UsedF2D = 1'b0; src2UsedF2D = 1'b0;
    destAddrAfterF2D = 3'd0;
    RWAfterF2D = 1'b0; MTRAfterF2D = 1'b0; isINAfterF2D = 1'b0;
    isBranchAfterF2D = 1'b0; takenBranch = 1'b0;
    memAccessAfterE2M = 1'b0;
    RWAfterM2W = 1'b0; isINAfterM2W = 1'b0; MEM_WB_RD = 3'd0;
  endtask

  task automatic dec(input logic [2:0] s1, input logic u1,
                     input logic [2:0] s2, input logic u2,
                     input logic [2:0] d, input logic rw,
                     input logic mtr, input logic isin, input logic br);
    src1AfterF2D = s1; src1UsedF2D = u1;
    src2AfterF2D = s2; src2UsedF2D = u2;
    destAddrAfterF2D = d; RWAfterF2D = rw;
    MTRAfterF2D = mtr; isINAfterF2D = isin; isBranchAfterF2D = br;
  endtask

  task automatic wb(input logic rw, input logic isin, input logic [2:0] rd);
    RWAfterM2W = rw; isINAfterM2W = isin; MEM_WB_RD = rd;
  endtask

  task automatic cyc();
    @(negedge clk);
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 expo("reset", 0, 0, 0, 0);
    perf("reset", 16'd0);

    // load-use
    cyc(); dec(0, 0, 0, 0, 3, 1, 1, 0, 0);
    #1 expo("ld_issue", 0, 0, 0, 0);
    cyc(); dec(3, 1, 1, 1, 5, 1, 0, 0, 0);
    #1 expo("ld_use", 1, 1, 0, 0);
    cyc(); dec(3, 1, 1, 1, 5, 1, 0, 0, 0);
    #1 expo("ld_use_go", 0, 0, 0, 0);

    // independent after load, src2 match but unused
    cyc(); dec(0, 0, 0, 0, 3, 1, 1, 0, 0);
    #1 expo("ld2_issue", 0, 0, 0, 0);
    cyc(); dec(4, 1, 3, 0, 6, 1, 0, 0, 0);
    #1 expo("ld_indep", 0, 0, 0, 0);

    // IN chain
    cyc(); dec(0, 0, 0, 0, 2, 1, 0, 1, 0);
    #1 expo("in_issue", 0, 0, 0, 0);
    cyc(); dec(2, 1, 0, 0, 6, 1, 0, 0, 0);
    #1 expo("in_wait1", 1, 1, 0, 0);
    cyc(); dec(2, 1, 0, 0, 6, 1, 0, 0, 0); wb(1, 0, 2);
    #1 expo("in_wait2", 1, 1, 0, 0);
    cyc(); dec(2, 1, 0, 0, 6, 1, 0, 0, 0); wb(1, 1, 2);
    #1 expo("in_wb_issue", 0, 0, 0, 0);
    cyc(); dec(0, 0, 2, 1, 6, 1, 0, 0, 0);
    #1 expo("in_clear", 0, 0, 0, 0);
    perf("after_in", 16'd3);

    // freeze with pending load-use; access ignored while frozen
    cyc(); dec(0, 0, 0, 0, 6, 1, 1, 0, 0); memAccessAfterE2M = 1'b1;
    #1 expo("frz_pre", 0, 0, 0, 0);
    cyc(); dec(6, 1, 0, 0, 7, 1, 0, 0, 0); memAccessAfterE2M = 1'b1;
    #1 expo("frz1", 0, 0, 0, 1);
    cyc(); dec(6, 1, 0, 0, 7, 1, 0, 0, 0);
    #1 expo("frz2", 0, 0, 0, 1);
    cyc(); dec(6, 1, 0, 0, 7, 1, 0, 0, 0);
    #1 expo("frz_ld_use", 1, 1, 0, 0);
    cyc(); dec(6, 1, 0, 0, 7, 1, 0, 0, 0);
    #1 expo("frz_ld_go", 0, 0, 0, 0);
    perf("after_frz", 16'd6);

    // taken branch during load-use, branch source hazard
    cyc(); dec(0, 0, 0, 0, 1, 1, 1, 0, 0);
    #1 expo("br_ld_issue", 0, 0, 0, 0);
    cyc(); dec(1, 1, 0, 0, 2, 1, 0, 0, 0); takenBranch = 1'b1;
    #1 expo("br_ld", 0, 1, 1, 0);
    cyc();
    #1 expo("br_after", 0, 0, 0, 0);
    cyc(); dec(0, 0, 0, 0, 4, 1, 1, 0, 0);
    #1 expo("br_ld2_issue", 0, 0, 0, 0);
    cyc(); dec(4, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 expo("br_src1", 1, 1, 0, 0);
    cyc(); dec(4, 0, 4, 0, 0, 0, 0, 0, 0);
    #1 expo("unused_srcs", 0, 0, 0, 0);
    perf("after_br", 16'd7);

    // IN count saturates at 3
    for (int i = 0; i < 4; i++) begin
      cyc(); dec(0, 0, 0, 0, 7, 1, 0, 1, 0);
      #1 expo("sat_issue", 0, 0, 0, 0);
    end
    cyc(); dec(0, 0, 7, 1, 0, 1, 0, 0, 0); wb(1, 1, 7);
    #1 expo("sat_wb1", 1, 1, 0, 0);
    cyc(); dec(0, 0, 7, 1, 0, 1, 0, 0, 0); wb(1, 1, 7);
    #1 expo("sat_wb2", 1, 1, 0, 0);
    cyc(); dec(0, 0, 7, 1, 0, 1, 0, 0, 0); wb(1, 1, 7);
    #1 expo("sat_wb3", 0, 0, 0, 0);

    // reset mid-freeze with a live IN count
    cyc(); dec(0, 0, 0, 0, 5, 1, 0, 1, 0);
    #1 expo("rst_in_issue", 0, 0, 0, 0);
    perf("after_sat", 16'd9);
    cyc(); memAccessAfterE2M = 1'b1;
    #1 expo("rst_pre", 0, 0, 0, 0);
    cyc(); rst = 1'b1;
    #1 expo("rst_frz", 0, 0, 0, 1);
    cyc(); rst = 1'b0; dec(5, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 expo("rst_after", 0, 0, 0, 0);
    perf("rst_after", 16'd0);

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
